conv_job_sequencer: RTL
=======================

Name: conv_job_sequencer

Overview:
- Sequences one convolution job at a time through the conv accelerator datapath.
- Accepts a job descriptor and validates it. Computes result_width/result_height with an iterative subtract-divider, so the datapath needs no hardware divider.
- Streams input words into the accelerator input memory, pulses start, and waits for done. Then streams the output memory back out with valid/ready.
- Sits between the system-side DMA/stream fabric and the conv engine.

Parameters:
- DSIZE, 1024, byte depth of the conv DI/DO memories.
- KSIZE, 5, maximum kernel edge accepted.
- AW, $clog2(DSIZE)+1, conv memory address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- cfg_valid / cfg_ready  in / out  1 / 1  descriptor handshake
- cfg_data_width, cfg_data_height  in  8 each  image dimensions
- cfg_stride_x, cfg_stride_y  in  4 each  strides
- cfg_kernel_width, cfg_kernel_height  in  4 each  kernel dimensions
- in_valid / in_ready / in_data  in / out / in  1 / 1 / 32  input pixel stream, 4 bytes per word, little-endian
- out_valid / out_ready / out_data / out_last  out / in / out / out  1 / 1 / 32 / 1  result stream
- conv_data_width, conv_data_height, conv_result_width, conv_result_height  out  8 each  registered job config to conv
- conv_stride_x, conv_stride_y, conv_kernel_width, conv_kernel_height  out  4 each  registered job config to conv
- conv_mi_addr / conv_mi_data / conv_mi_wr  out  AW / 32 / 1  conv input memory write port
- conv_mo_addr / conv_mo_data  out / in  AW / 32  conv output memory read port
- conv_start / conv_done  out / in  1 / 1  conv control
- busy  out  1  high whenever state != IDLE
- job_done  out  1  one-cycle pulse when the final output word is accepted
- err / err_code  out  1 / 2  one-cycle pulse with reason code; 1 = stride zero, 2 = kernel larger than image or KSIZE, 3 = image larger than DSIZE

Behaviour:
- Reset values: all outputs 0; state IDLE.
- States: IDLE, CHECK, DIV_X, DIV_Y, LOAD, RUN, DRAIN.
- IDLE:
  - cfg_ready = 1.
  - On cfg_valid: latch all fields into the conv_* config registers and go to CHECK.
  - Config registers are stable from then until the next accepted descriptor.
- CHECK (1 cycle):
  - On an error condition, evaluated in code order 1, 2, 3: pulse err with err_code, then IDLE. conv_start is never asserted.
  - Otherwise compute nbytes = dw*dh and nwords = ceil(nbytes/4), then go to DIV_X.
- DIV_X, then DIV_Y:
  - Quotient register starts at 0; remainder starts at (dw-kw) for DIV_X, (dh-kh) for DIV_Y.
  - Each cycle: if remainder >= stride, subtract stride and increment quotient; else write the quotient to conv_result_width (or conv_result_height) and advance.
  - Takes quotient+1 cycles. Example: (10-3)/2 = 3 takes 4 cycles.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready beat: conv_mi_wr = 1, conv_mi_data = in_data, conv_mi_addr = 4*k for beat k.
  - After nwords beats go to RUN. in_ready drops in the same cycle the last beat is accepted.
- RUN:
  - conv_start is high for exactly the first RUN cycle.
  - Wait for conv_done high, sampled from the cycle after start, then go to DRAIN.
- DRAIN:
  - out_valid = 1 and out_data = conv_mo_data combinationally, with conv_mo_addr = 4*k.
  - conv_mo_addr and out_data hold while out_ready is low.
  - out_last is high on word nwords-1. On that beat's acceptance: pulse job_done, go to IDLE.
- cfg_ready = 0 outside IDLE. Descriptors presented while busy are not consumed.
- in_ready = 0 outside LOAD; out_valid = 0 outside DRAIN.
- Asynchronous reset mid-job returns to IDLE immediately. No job_done or err pulse follows; conv memories are left untouched.
- A conv_done seen in any state other than RUN is ignored.
- Width rules:
  - nbytes is 16-bit.
  - Word counters are AW bits; addresses are word index shifted left by 2.

Decomposition:
- Shared package conv_pkg holds:
  - the state enum;
  - the err_code constants ERR_STRIDE, ERR_KSIZE, ERR_DSIZE;
  - the DSIZE/KSIZE defaults.
- One natural sub-module: conv_iter_div, an 8-bit by 4-bit sequential subtract-divider with start/done handshake. It is instantiated once and reused for X then Y.

Test Plan:
- Descriptor dw=8, dh=8, kw=3, kh=3, sx=1, sy=1 -> conv_result_width=5, conv_result_height=5; LOAD takes exactly 16 beats at mi_addr 0,4,...,60; one conv_start pulse; DRAIN emits 16 words with out_last on the 16th; job_done pulses once.
- dw=10, kw=3, sx=2 -> conv_result_width=3 after exactly 4 DIV_X cycles; stride_y=4 with dh=10, kh=2 -> conv_result_height=2.
- Three bad descriptors, each followed by a valid job:
  - sx=0 -> err=1, code 1;
  - kw=6 -> code 2;
  - dw=dh=40 -> code 3.
  - In every case conv_start stays 0, busy returns to 0 within 2 cycles, and the subsequent valid job completes normally.
- Backpressure: in_valid toggled every other cycle and out_ready low for 5 cycles mid-DRAIN -> no lost or duplicated words; conv_mo_addr and out_data held stable while out_ready is low.
- Assert rst_n low during RUN with conv_done still pending -> all outputs 0 next edge; a later conv_done pulse in IDLE causes no transition; a new job then runs cleanly.
- dw=5, dh=3 (15 bytes) -> nwords=4; out_last on 4th word.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the conv job sequencer
package conv_pkg;

  localparam int DSIZE_DEF = 1024;  // byte depth of the conv DI/DO memories
  localparam int KSIZE_DEF = 5;     // largest kernel edge accepted

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_STRIDE = 2'd1;
  localparam logic [1:0] ERR_KSIZE  = 2'd2;
  localparam logic [1:0] ERR_DSIZE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV_X,
    ST_DIV_Y,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// rtl/conv_job_sequencer_if.sv - descriptor, input stream and result stream bundle
// Ports (slave = sequencer side):
//   cfg_*  : descriptor handshake and fields (master -> slave, cfg_ready back)
//   in_*   : 32-bit input pixel stream, 4 bytes per word little-endian
//   out_*  : 32-bit result stream with out_last on the final word
interface conv_job_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data_width;
  logic [7:0]  cfg_data_height;
  logic [3:0]  cfg_stride_x;
  logic [3:0]  cfg_stride_y;
  logic [3:0]  cfg_kernel_width;
  logic [3:0]  cfg_kernel_height;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output cfg_valid, cfg_data_width, cfg_data_height, cfg_stride_x, cfg_stride_y,
           cfg_kernel_width, cfg_kernel_height,
    input  cfg_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  cfg_valid, cfg_data_width, cfg_data_height, cfg_stride_x, cfg_stride_y,
           cfg_kernel_width, cfg_kernel_height,
    output cfg_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );
endinterface

// File: rtl/conv_iter_div.sv
// rtl/conv_iter_div.sv - 8-bit by 4-bit sequential subtract divider
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor and begin (takes priority over a running division)
//   dividend   : 8-bit numerator, divisor : 4-bit denominator (must be non-zero)
//   done       : high for the single cycle in which the quotient is final
//   quotient   : running quotient, final while done is high
module conv_iter_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       done,
  output logic [7:0] quotient
);

  logic [7:0] rem_q;
  logic [7:0] quot_q;
  logic [3:0] div_q;
  logic       active_q;
  logic       can_sub;

  assign can_sub  = rem_q >= {4'd0, div_q};
  // One subtraction per cycle; the first cycle that cannot subtract reports done,
  // so a division costs quotient+1 cycles.
  assign done     = active_q && !can_sub;
  assign quotient = quot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= 8'd0;
      quot_q   <= 8'd0;
      div_q    <= 4'd0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= dividend;
      quot_q   <= 8'd0;
      div_q    <= divisor;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (can_sub) begin
        rem_q  <= rem_q - {4'd0, div_q};
        quot_q <= quot_q + 8'd1;
      end else begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/conv_job_sequencer.sv
// rtl/conv_job_sequencer.sv - sequences one convolution job through the conv engine
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : descriptor handshake, input pixel stream, result stream
//   conv_* config       : registered job configuration, stable until next descriptor
//   conv_mi_*           : conv input memory write port (byte address = 4 * word)
//   conv_mo_*           : conv output memory read port (combinational read data)
//   conv_start/done     : engine kick and completion
//   busy                : high whenever not idle
//   job_done            : pulse on acceptance of the final result word
//   err/err_code        : pulse with reason when a descriptor is rejected
module conv_job_sequencer
  import conv_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int KSIZE = KSIZE_DEF,
  parameter int AW    = $clog2(DSIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_job_sequencer_if.slave  bus,
  output logic [7:0]           conv_data_width,
  output logic [7:0]           conv_data_height,
  output logic [7:0]           conv_result_width,
  output logic [7:0]           conv_result_height,
  output logic [3:0]           conv_stride_x,
  output logic [3:0]           conv_stride_y,
  output logic [3:0]           conv_kernel_width,
  output logic [3:0]           conv_kernel_height,
  output logic [AW-1:0]        conv_mi_addr,
  output logic [31:0]          conv_mi_data,
  output logic                 conv_mi_wr,
  output logic [AW-1:0]        conv_mo_addr,
  input  logic [31:0]          conv_mo_data,
  output logic                 conv_start,
  input  logic                 conv_done,
  output logic                 busy,
  output logic                 job_done,
  output logic                 err,
  output logic [1:0]           err_code
);

  localparam logic [7:0]  KMAX = 8'(KSIZE);
  localparam logic [16:0] DMAX = 17'(DSIZE);

  state_t        state_q, state_d;
  logic [AW-1:0] nwords_q;
  logic [AW-1:0] cnt_q;
  logic          run_first_q;

  logic [15:0]   nbytes;
  logic [16:0]   nwords_full;
  logic [1:0]    chk_code;
  logic          in_beat, out_beat, last_word;
  logic [AW-1:0] word_addr;

  logic          div_start, div_done;
  logic [7:0]    div_dividend, div_quot;
  logic [3:0]    div_divisor;

  conv_iter_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Descriptor validation on the latched config; first failing rule wins.
  always_comb begin
    nbytes      = {8'd0, conv_data_width} * {8'd0, conv_data_height};
    nwords_full = ({1'b0, nbytes} + 17'd3) >> 2;
    chk_code    = ERR_NONE;
    if (conv_stride_x == 4'd0 || conv_stride_y == 4'd0) begin
      chk_code = ERR_STRIDE;
    end else if ({4'd0, conv_kernel_width} > conv_data_width ||
                 {4'd0, conv_kernel_height} > conv_data_height ||
                 {4'd0, conv_kernel_width} > KMAX ||
                 {4'd0, conv_kernel_height} > KMAX) begin
      chk_code = ERR_KSIZE;
    end else if ({1'b0, nbytes} > DMAX) begin
      chk_code = ERR_DSIZE;
    end
  end

  assign in_beat   = bus.in_valid && (state_q == ST_LOAD);
  assign out_beat  = bus.out_ready && (state_q == ST_DRAIN);
  assign last_word = (cnt_q == (nwords_q - AW'(1)));
  assign word_addr = AW'({cnt_q, 2'b00});

  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_dividend = conv_data_width - {4'd0, conv_kernel_width};
    div_divisor  = conv_stride_x;
    case (state_q)
      ST_IDLE:  if (bus.cfg_valid) state_d = ST_CHECK;
      ST_CHECK: begin
        if (chk_code != ERR_NONE) begin
          state_d = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV_X;
        end
      end
      ST_DIV_X: begin
        // The single divider is reloaded with the Y operands on the X done cycle.
        if (div_done) begin
          div_start    = 1'b1;
          div_dividend = conv_data_height - {4'd0, conv_kernel_height};
          div_divisor  = conv_stride_y;
          state_d      = ST_DIV_Y;
        end
      end
      ST_DIV_Y: if (div_done) state_d = ST_LOAD;
      ST_LOAD:  if (in_beat && last_word) state_d = ST_RUN;
      // conv_done is only honoured after the start cycle.
      ST_RUN:   if (!run_first_q && conv_done) state_d = ST_DRAIN;
      ST_DRAIN: if (out_beat && last_word) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // cfg_ready is held low while reset is asserted so every output reads 0 in reset.
  assign bus.cfg_ready = rst_n && (state_q == ST_IDLE);
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.out_data  = (state_q == ST_DRAIN) ? conv_mo_data : 32'd0;
  assign bus.out_last  = (state_q == ST_DRAIN) && last_word;

  assign conv_mi_wr   = in_beat;
  assign conv_mi_data = (state_q == ST_LOAD) ? bus.in_data : 32'd0;
  assign conv_mi_addr = (state_q == ST_LOAD) ? word_addr : '0;
  assign conv_mo_addr = (state_q == ST_DRAIN) ? word_addr : '0;
  assign conv_start   = (state_q == ST_RUN) && run_first_q;

  assign busy     = (state_q != ST_IDLE);
  assign job_done = out_beat && last_word;
  assign err      = (state_q == ST_CHECK) && (chk_code != ERR_NONE);
  assign err_code = (state_q == ST_CHECK) ? chk_code : ERR_NONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      conv_data_width    <= 8'd0;
      conv_data_height   <= 8'd0;
      conv_result_width  <= 8'd0;
      conv_result_height <= 8'd0;
      conv_stride_x      <= 4'd0;
      conv_stride_y      <= 4'd0;
      conv_kernel_width  <= 4'd0;
      conv_kernel_height <= 4'd0;
      nwords_q           <= '0;
      cnt_q              <= '0;
      run_first_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.cfg_valid) begin
        conv_data_width    <= bus.cfg_data_width;
        conv_data_height   <= bus.cfg_data_height;
        conv_stride_x      <= bus.cfg_stride_x;
        conv_stride_y      <= bus.cfg_stride_y;
        conv_kernel_width  <= bus.cfg_kernel_width;
        conv_kernel_height <= bus.cfg_kernel_height;
      end
      if (state_q == ST_CHECK) nwords_q <= AW'(nwords_full);
      if (state_q == ST_DIV_X && div_done) conv_result_width <= div_quot;
      if (state_q == ST_DIV_Y && div_done) conv_result_height <= div_quot;
      // One counter serves LOAD then DRAIN; it wraps to 0 on the last word of each.
      if (in_beat || out_beat) cnt_q <= last_word ? '0 : cnt_q + AW'(1);
      run_first_q <= in_beat && last_word;
    end
  end

endmodule
